// File: rtl/program_loader.sv
// Streams an image buffer into a CPU over its ready/done_load handshake, then
// waits for the CPU to halt and latches its output.
module program_loader #(
  parameter int PROG_BYTES  = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       img_we,
  input  logic [3:0] img_addr,
  input  logic [7:0] img_data,
  input  logic [4:0] prog_len,
  input  logic       start,
  input  logic       abort,
  input  logic       cpu_ready,
  input  logic       cpu_done_load,
  input  logic       cpu_halt,
  input  logic [7:0] cpu_out,
  output logic       programming,
  output logic [7:0] ui_data,
  output logic       busy,
  output logic       halted,
  output logic [7:0] result,
  output logic [4:0] bytes_sent,
  output logic [1:0] err_code
);
  localparam int AW = (PROG_BYTES > 1) ? $clog2(PROG_BYTES) : 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ARM       = 3'd1;
  localparam logic [2:0] S_SEND      = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_RUN       = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;
  localparam logic [2:0] S_ERROR     = 3'd6;

  localparam logic [1:0] E_NONE    = 2'b00;
  localparam logic [1:0] E_TIMEOUT = 2'b01;
  localparam logic [1:0] E_EARLY   = 2'b10;
  localparam logic [1:0] E_LEN     = 2'b11;

  logic [7:0] image [PROG_BYTES];
  logic [2:0] state, state_n;
  logic [1:0] err_n;
  logic [4:0] len;
  logic [7:0] wait_cnt;
  logic       ready_q, done_q, halt_q;

  logic idle_like, loading_n, any_edge, ready_fall, halt_rise, len_bad, timeout, last_byte;

  assign idle_like  = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);
  assign loading_n  = (state_n == S_ARM) || (state_n == S_SEND) || (state_n == S_WAIT_DONE);
  assign any_edge   = (ready_q ^ cpu_ready) | (done_q ^ cpu_done_load);
  assign ready_fall = ready_q & ~cpu_ready;
  assign halt_rise  = cpu_halt & ~halt_q;
  assign len_bad    = (prog_len == 5'd0) || (prog_len > 5'(PROG_BYTES));
  // Any handshake edge this cycle counts as progress, even at the limit.
  assign timeout    = (wait_cnt == 8'(TIMEOUT_CYC)) && !any_edge;
  assign last_byte  = ready_fall && (5'(bytes_sent + 5'd1) == len);

  assign ui_data = (state == S_SEND) ? image[bytes_sent[AW-1:0]] : 8'h00;

  always_comb begin
    state_n = state;
    err_n   = err_code;
    if (abort) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            if (len_bad) begin
              state_n = S_ERROR;
              err_n   = E_LEN;
            end else begin
              state_n = S_ARM;
              err_n   = E_NONE;
            end
          end
        end
        S_ARM, S_SEND: begin
          if (cpu_done_load && (bytes_sent < len)) begin
            state_n = S_ERROR;
            err_n   = E_EARLY;
          end else if (timeout) begin
            state_n = S_ERROR;
            err_n   = E_TIMEOUT;
          end else if (state == S_ARM) begin
            if (cpu_ready) state_n = S_SEND;
          end else if (last_byte) begin
            state_n = S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (cpu_done_load) begin
            state_n = S_RUN;
          end else if (timeout) begin
            state_n = S_ERROR;
            err_n   = E_TIMEOUT;
          end
        end
        S_RUN: if (halt_rise) state_n = S_DONE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      err_code    <= E_NONE;
      programming <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      result      <= 8'h00;
      bytes_sent  <= 5'd0;
      len         <= 5'd0;
      wait_cnt    <= 8'd0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      halt_q      <= 1'b0;
    end else begin
      state       <= state_n;
      err_code    <= err_n;
      programming <= loading_n;
      busy        <= !((state_n == S_IDLE) || (state_n == S_DONE) || (state_n == S_ERROR));
      ready_q     <= cpu_ready;
      done_q      <= cpu_done_load;
      halt_q      <= cpu_halt;

      if (!abort) begin
        if (idle_like && start && !len_bad) begin
          bytes_sent <= 5'd0;
          halted     <= 1'b0;
          result     <= 8'h00;
          len        <= prog_len;
        end
        if (state == S_SEND && ready_fall) bytes_sent <= bytes_sent + 5'd1;
        if (state == S_RUN && halt_rise) begin
          result <= cpu_out;
          halted <= 1'b1;
        end
      end

      if (!loading_n || state_n != state || any_edge) wait_cnt <= 8'd0;
      else                                            wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Image survives reset; a start in the same cycle wins over the write.
  always_ff @(posedge clk) begin
    if (img_we && !busy && !start) image[img_addr[AW-1:0]] <= img_data;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter PROG_BYTES, default 16: image depth in bytes, matching CPU RAM size.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 255: maximum cycles waited for each CPU handshake edge during loading.
REQ-003 SHALL have the following ports; clk and rst form the one clock, with synchronous active-high reset:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- img_we  in  1  image buffer write strobe.
- img_addr  in  4  image buffer write address.
- img_data  in  8  image buffer write data.
- prog_len  in  5  number of bytes to load, 1..16.
- start  in  1  begin load-and-run, one-cycle pulse.
- abort  in  1  return to IDLE immediately.
- cpu_ready  in  1  CPU ready-for-byte flag (CPU uio_out[1]).
- cpu_done_load  in  1  CPU done-loading flag (CPU uio_out[2]).
- cpu_halt  in  1  CPU halt flag (CPU uio_out[5]).
- cpu_out  in  8  CPU output register (CPU uo_out).
- programming  out  1  drives CPU programming-mode input (CPU uio_in[0]).
- ui_data  out  8  byte presented to CPU ui_in.
- busy  out  1  high in any state except IDLE, DONE and ERROR.
- halted  out  1  CPU program completed and result is valid.
- result  out  8  cpu_out value latched at halt.
- bytes_sent  out  5  count of bytes consumed by the CPU.
- err_code  out  2  00 none, 01 timeout, 10 early done_load, 11 bad length.

Function
REQ-004 SHALL store a PROG_BYTES x 8 image buffer, written on clk when img_we=1 and busy=0; writes while busy SHALL be ignored.
REQ-005 SHALL implement the FSM states IDLE, ARM, SEND, WAIT_DONE, RUN, DONE and ERROR.
REQ-006 SHALL, in IDLE, DONE or ERROR, on start=1: go to ERROR with err_code=11 if prog_len=0 or prog_len>16; otherwise go to ARM, clearing bytes_sent, halted, result and err_code.
REQ-007 SHALL ignore start while busy=1.
REQ-008 SHALL hold programming=1 in ARM, SEND and WAIT_DONE, and hold programming=0 in every other state.
REQ-009 SHALL, in ARM, move to SEND on the first cycle cpu_ready=1 is sampled.
REQ-010 SHALL drive ui_data = image[bytes_sent] combinationally from registered state while in SEND, and drive ui_data=0 in every other state.
REQ-011 SHALL treat a byte as consumed on a sampled cpu_ready falling edge (1 in the previous cycle, 0 in the current cycle); bytes_sent SHALL increment in the following cycle.
REQ-012 SHALL move from SEND to WAIT_DONE when bytes_sent reaches prog_len.
REQ-013 SHALL, in WAIT_DONE, move to RUN the cycle after cpu_done_load=1 is sampled.
REQ-014 SHALL, in ARM or SEND, go to ERROR with err_code=10 if cpu_done_load=1 is sampled while bytes_sent<prog_len.
REQ-015 SHALL use an 8-bit wait counter: cleared on entry to ARM, SEND and WAIT_DONE and on every cpu_ready or cpu_done_load edge, incremented otherwise; when the counter reaches TIMEOUT_CYC, the block SHALL go to ERROR with err_code=01.
REQ-016 SHALL, in RUN, on a sampled cpu_halt rising edge, latch result=cpu_out, set halted=1 and go to DONE; RUN SHALL have no timeout.
REQ-017 SHALL have abort override all other inputs: from any state the block SHALL go to IDLE next cycle, with programming=0 and busy=0; bytes_sent, result and err_code SHALL be held.
REQ-018 SHALL give start precedence over a coincident img_we in IDLE; the write SHALL be dropped.
REQ-019 SHALL hold outputs in DONE and ERROR until the next start, abort or rst.
REQ-020 SHALL register all outputs except ui_data.

Reset
REQ-021 SHALL, on rst=1 at a clk edge: state=IDLE, programming=0, ui_data=0, busy=0, halted=0, result=0, bytes_sent=0, err_code=00, wait counter=0, edge-detect registers=0.
REQ-022 SHALL NOT clear the image buffer on reset.
REQ-023 SHALL, on rst mid-load, deassert programming on the cycle after the reset edge.

Verification
REQ-024 Nominal: image[0..2]={0x1E,0x2F,0xF0}, prog_len=3, start; CPU model pulses ready three times, then done_load, then halt with cpu_out=0x2A -> ui_data shows 0x1E, 0x2F, 0xF0 in order; bytes_sent=3; programming falls after done_load; result=0x2A, halted=1.
REQ-025 Timeout: prog_len=4, start, CPU never asserts ready -> ERROR, err_code=01, programming=0 after 255 cycles in ARM.
REQ-026 Early done: prog_len=5, done_load asserted after 2 bytes -> ERROR, err_code=10, bytes_sent=2.
REQ-027 Bad length: prog_len=0 and, separately, prog_len=17, start -> ERROR with err_code=11 next cycle; programming never asserts.
REQ-028 Abort/reset mid-SEND: after 1 byte, abort=1 -> IDLE, programming=0 next cycle, bytes_sent=1 held; repeat with rst -> all outputs at reset values; an image write while busy is ignored.
